mmio_bridge: RTL

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_tx_fifo.sv | 47 ++++
 rtl/mmio_bridge.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO bridge definitions: IO base, register offsets, region and read-source encodings.
package mmio_pkg;
  localparam logic [17:0] IO_BASE  = 18'h30000;
  localparam logic [2:0]  OFF_TX   = 3'h0;
  localparam logic [2:0]  OFF_STOP = 3'h4;

  typedef enum logic { RGN_RAM = 1'b0, RGN_IO = 1'b1 } region_e;
  typedef enum logic [1:0] { SRC_RAM, SRC_ZERO, SRC_RX, SRC_SNAP } src_e;

  function automatic region_e decode(input logic [17:0] a);
    return (a[17:16] == IO_BASE[17:16]) ? RGN_IO : RGN_RAM;
  endfunction
endpackage

// File: rtl/mmio_tx_fifo.sv
// UART TX byte FIFO; pushes while full are dropped by the FIFO itself.
module mmio_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 wdata,
  input  logic                       pop,
  output logic [7:0]                 rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-RAM/IO bridge with UART TX FIFO, cycle counter snapshot and program-stop flag.
// Optional UART RX read register enabled by defining MMIO_RX_EN.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_stop,
  output logic        tx_overflow
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] THRESH = CW'(TX_DEPTH - FULL_MARGIN);

  region_e       rgn, rgn_q;
  logic          io_hit, io_wr, io_rd;
  logic [2:0]    off, off_q;
  logic          hit_q, rd_q;
  logic          push, fifo_full, fifo_empty;
  logic [7:0]    push_data;
  logic [CW-1:0] count;
  logic [31:0]   cnt, snap;
  logic [7:0]    rx_q;
  src_e          src;

  assign rgn       = decode(mem_a[17:0]);
  assign off       = mem_a[2:0];
  assign io_hit    = (rgn == RGN_IO) && (mem_a[15:3] == '0);
  assign io_wr     = mem_wr && io_hit;
  assign io_rd     = !mem_wr && io_hit;

  assign ram_a     = mem_a[16:0];
  assign ram_wdata = mem_dout;
  assign ram_we    = mem_wr && (rgn == RGN_RAM);

  // A stop write also emits a 0x00 marker byte on the UART.
  assign push      = io_wr && ((off == OFF_TX && mem_dout != 8'h00) || off == OFF_STOP);
  assign push_data = (off == OFF_STOP) ? 8'h00 : mem_dout;
  assign tx_valid  = !fifo_empty;

  mmio_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (push),
    .wdata (push_data),
    .pop   (tx_valid && tx_ready),
    .rdata (tx_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt            <= '0;
      snap           <= '0;
      prog_stop      <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
      rgn_q          <= RGN_IO;
      hit_q          <= 1'b0;
      rd_q           <= 1'b0;
      off_q          <= '0;
    end else begin
      cnt            <= cnt + 32'd1;
      io_buffer_full <= (count >= THRESH);
      rgn_q          <= rgn;
      hit_q          <= io_hit;
      rd_q           <= !mem_wr;
      off_q          <= off;
      if (io_rd && off == OFF_STOP) snap <= cnt;
      if (io_wr && off == OFF_STOP) prog_stop <= 1'b1;
      if (push && fifo_full)        tx_overflow <= 1'b1;
    end
  end

`ifdef MMIO_RX_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_q   <= '0;
      rx_pop <= 1'b0;
    end else begin
      rx_pop <= io_rd && off == OFF_TX && rx_valid;
      if (io_rd && off == OFF_TX) rx_q <= rx_valid ? rx_data : 8'h00;
    end
  end
  logic unused;
  assign unused = ^{mem_a[31:18]};
`else
  assign rx_q   = 8'h00;
  assign rx_pop = 1'b0;
  logic unused;
  assign unused = ^{mem_a[31:18], rx_data, rx_valid};
`endif

  // Read mux works entirely from last cycle's latched address, so IO-then-RAM has no bubble.
  always_comb begin
    src = SRC_ZERO;
    if (rgn_q == RGN_RAM)                    src = SRC_RAM;
    else if (hit_q && rd_q && off_q == OFF_TX) src = SRC_RX;
    else if (hit_q && rd_q && off_q[2])      src = SRC_SNAP;
  end

  always_comb begin
    case (src)
      SRC_RAM:  mem_din = ram_rdata;
      SRC_RX:   mem_din = rx_q;
      SRC_SNAP: mem_din = snap[8*off_q[1:0] +: 8];
      default:  mem_din = 8'h00;
    endcase
  end
endmodule
